// File: rtl/tick_counter_if.sv
// Signal bundle between tick_counter and its user: the slow-clock input, the
// control strobes, and the tick/count/status outputs.
interface tick_counter_if;
    logic       slowIn;
    logic       enable;
    logic       clear;
    logic       tick;
    logic [7:0] count;
    logic       wrap;
    logic       running;
    logic       stalled;

    modport slave (
        input  slowIn, enable, clear,
        output tick, count, wrap, running, stalled
    );

    modport master (
        output slowIn, enable, clear,
        input  tick, count, wrap, running, stalled
    );
endinterface

// File: rtl/tick_counter.sv
// Counts rising edges of an asynchronous divided clock, modulo MAX_COUNT.
// Define TICK_COUNTER_WATCHDOG_EN to build in the RUN->STALL watchdog.
module tick_counter #(
    parameter int MAX_COUNT = 10,
    parameter int TIMEOUT   = 256
) (
    input  logic           clkIn,
    input  logic           reset,
    tick_counter_if.slave  bus
);

    //  state | meaning
    //  IDLE  | no tick seen since reset
    //  RUN   | ticks arriving
    //  STALL | no tick for TIMEOUT cycles (watchdog build only)
    typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

    localparam logic [7:0] CNT_LAST = 8'(MAX_COUNT - 1);

    if (MAX_COUNT < 2 || MAX_COUNT > 256 || TIMEOUT < 2 || TIMEOUT > 65536) begin : g_param_check
        $error("tick_counter: MAX_COUNT or TIMEOUT out of range");
    end

    logic       sync1;
    logic       sync2;
    logic       prev;
    logic       tick;
    logic [7:0] count;
    logic       wrap;
    logic       running;
    logic       stalled;
    state_t     state;

    always_ff @(posedge clkIn) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            tick  <= 1'b0;
        end else begin
            sync1 <= bus.slowIn;
            sync2 <= sync1;
            prev  <= sync2;
            tick  <= sync2 & ~prev;
        end
    end

    // Clear wins over enable and never raises wrap.
    always_ff @(posedge clkIn) begin
        if (reset) begin
            count <= 8'd0;
            wrap  <= 1'b0;
        end else if (bus.clear) begin
            count <= 8'd0;
            wrap  <= 1'b0;
        end else if (bus.enable && tick) begin
            if (count == CNT_LAST) begin
                count <= 8'd0;
                wrap  <= 1'b1;
            end else begin
                count <= count + 8'd1;
                wrap  <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

`ifdef TICK_COUNTER_WATCHDOG_EN
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    logic [15:0] timer;

    always_ff @(posedge clkIn) begin
        if (reset) begin
            state   <= IDLE;
            running <= 1'b0;
            stalled <= 1'b0;
            timer   <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    timer <= 16'd0;
                    if (tick) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    // A tick landing on the timeout cycle keeps us running.
                    if (tick) begin
                        timer <= 16'd0;
                    end else if (timer == TIMER_LAST) begin
                        state   <= STALL;
                        running <= 1'b0;
                        stalled <= 1'b1;
                        timer   <= 16'd0;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                STALL: begin
                    timer <= 16'd0;
                    if (tick) begin
                        state   <= RUN;
                        running <= 1'b1;
                        stalled <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    stalled <= 1'b0;
                    timer   <= 16'd0;
                end
            endcase
        end
    end
`else
    // Without the watchdog RUN is terminal until reset.
    always_ff @(posedge clkIn) begin
        if (reset) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    state   <= RUN;
                    running <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    assign stalled = 1'b0;
`endif

    assign bus.tick    = tick;
    assign bus.count   = count;
    assign bus.wrap    = wrap;
    assign bus.running = running;
    assign bus.stalled = stalled;

endmodule

// File: tb/tb_tick_counter.sv
// Directed bench for tick_counter (MAX_COUNT=10, TIMEOUT=20); the watchdog
// section runs only when TICK_COUNTER_WATCHDOG_EN is defined.
module tb_tick_counter;

    logic clk_sys = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_wraps  = 0;

    tick_counter_if bus ();

    tick_counter #(
        .MAX_COUNT(10),
        .TIMEOUT  (20)
    ) dut (
        .clkIn(clk_sys),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        bus.slowIn = 1'b0;
        bus.clear  = 1'b0;
        step(2);
        reset = 1'b0;
        step(2);
    endtask

    // One slowIn period (4 high, 4 low). Rise is sampled at E1, tick shows
    // after E3 only, count/wrap update at E4.
    task automatic slow_period(input int exp_count, input bit exp_wrap,
                               input bit en, input bit clr, input bit first);
        bus.slowIn = 1'b1;
        bus.enable = en;
        step(2);
        chk("tick_early", bus.tick, 0);
        step(1);
        chk("tick_pulse", bus.tick, 1);
        if (first) chk("idle_before_tick", bus.running, 0);
        if (clr) bus.clear = 1'b1;
        step(1);
        bus.clear = 1'b0;
        chk("tick_width", bus.tick, 0);
        chk("count", bus.count, exp_count);
        chk("wrap", bus.wrap, exp_wrap);
        chk("running", bus.running, 1);
        chk("stalled_run", bus.stalled, 0);
        if (bus.wrap) n_wraps++;
        bus.slowIn = 1'b0;
        step(1);
        chk("wrap_width", bus.wrap, 0);
        step(2);
        chk("tick_fall", bus.tick, 0);
        step(1);
    endtask

    initial begin
        reset      = 1'b1;
        bus.slowIn = 1'b0;
        bus.enable = 1'b1;
        bus.clear  = 1'b0;
        step(2);
        chk("rst_tick", bus.tick, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_wrap", bus.wrap, 0);
        chk("rst_running", bus.running, 0);
        chk("rst_stalled", bus.stalled, 0);
        reset = 1'b0;
        step(3);
        chk("idle_no_tick", bus.tick, 0);

        // 25 periods: 1..9,0,1..9,0,1..5 with two wraps
        slow_period(1, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int p = 2; p <= 25; p++)
            slow_period(p % 10, (p % 10) == 0, 1'b1, 1'b0, 1'b0);
        chk("wrap_total", n_wraps, 2);
        chk("final_count", bus.count, 5);

        // enable low for periods 3-5, then clear coincident with a tick
        do_reset();
        slow_period(1, 1'b0, 1'b1, 1'b0, 1'b1);
        slow_period(2, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int p = 3; p <= 5; p++)
            slow_period(2, 1'b0, 1'b0, 1'b0, 1'b0);
        slow_period(0, 1'b0, 1'b1, 1'b1, 1'b0);
        slow_period(1, 1'b0, 1'b1, 1'b0, 1'b0);

        // reset at count 7 with a tick already in the synchronizer
        do_reset();
        for (int p = 1; p <= 7; p++)
            slow_period(p, 1'b0, 1'b1, 1'b0, p == 1);
        chk("pre_rst_count", bus.count, 7);
        bus.slowIn = 1'b1;
        step(2);
        reset = 1'b1;
        step(1);
        chk("mid_rst_tick", bus.tick, 0);
        chk("mid_rst_count", bus.count, 0);
        chk("mid_rst_wrap", bus.wrap, 0);
        chk("mid_rst_running", bus.running, 0);
        chk("mid_rst_stalled", bus.stalled, 0);
        bus.slowIn = 1'b0;
        step(1);
        reset = 1'b0;
        step(3);
        chk("post_rst_tick", bus.tick, 0);
        slow_period(1, 1'b0, 1'b1, 1'b0, 1'b1);
        slow_period(2, 1'b0, 1'b1, 1'b0, 1'b0);

        // three ticks then silence
        do_reset();
        for (int p = 1; p <= 3; p++)
            slow_period(p, 1'b0, 1'b1, 1'b0, p == 1);
`ifdef TICK_COUNTER_WATCHDOG_EN
        // last tick sampled at E4; stall visible 20 edges later
        step(15);
        chk("pre_stall_stalled", bus.stalled, 0);
        chk("pre_stall_running", bus.running, 1);
        step(1);
        chk("stall_stalled", bus.stalled, 1);
        chk("stall_running", bus.running, 0);
        step(5);
        chk("stall_hold", bus.stalled, 1);
        slow_period(4, 1'b0, 1'b1, 1'b0, 1'b1);
        slow_period(5, 1'b0, 1'b1, 1'b0, 1'b0);
`else
        step(60);
        chk("no_wd_running", bus.running, 1);
        chk("no_wd_stalled", bus.stalled, 0);
        slow_period(4, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tick_counter.md
TICK_COUNTER -- requirements
Module: tick_counter

Interface
REQ-001 SHALL have parameter MAX_COUNT, default 10: count modulus; legal range 2..256.
REQ-002 SHALL have parameter TIMEOUT, default 256: clkIn cycles without a tick before stall; legal range 2..65536.
REQ-003 SHALL have port clkIn, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port slowIn, input, 1 bit: divided clock from the upstream divider; asynchronous to clkIn.
REQ-006 SHALL have port enable, input, 1 bit: count advance enable.
REQ-007 SHALL have port clear, input, 1 bit: synchronous count clear.
REQ-008 SHALL have port tick, output, 1 bit: one-cycle pulse per slowIn rising edge.
REQ-009 SHALL have port count, output, 8 bits: modulo-MAX_COUNT tick count.
REQ-010 SHALL have port wrap, output, 1 bit: one-cycle pulse when count wraps to 0.
REQ-011 SHALL have port running, output, 1 bit: high in state RUN.
REQ-012 SHALL have port stalled, output, 1 bit: high in state STALL.

Function
REQ-013 SHALL sample slowIn through a 2-flop synchronizer (sync1, sync2) plus a history flop (prev).
REQ-014 SHALL register tick <= sync2 & ~prev; tick is high for exactly one clkIn cycle per slowIn rising edge and never for a falling edge.
REQ-015 Tick latency SHALL be fixed: if slowIn is first sampled high at clkIn edge N, tick is high from edge N+2 to edge N+3.
REQ-016 SHALL update count on the clkIn edge where tick is high, with priority order: clear, then enable.
REQ-017 When clear=1, SHALL set count to 0 next edge, suppress wrap, and leave tick and FSM unaffected.
REQ-018 When clear=0, enable=1 and tick=1, SHALL set count to 0 if count==MAX_COUNT-1, else to count+1.
REQ-019 On every increment, count arithmetic SHALL be 8-bit and never reach MAX_COUNT.
REQ-020 When enable=0, SHALL hold count; ticks are still generated.
REQ-021 SHALL pulse wrap high for exactly the one cycle in which count first shows 0 after a MAX_COUNT-1 -> 0 transition; wrap is registered alongside count.
REQ-022 SHALL implement FSM states IDLE, RUN and STALL.
REQ-023 SHALL transition IDLE->RUN on tick.
REQ-024 SHALL transition STALL->RUN on tick.
REQ-025 SHALL transition RUN->STALL per REQ-032; there is no other transition.
REQ-026 SHALL drive running and stalled as registered decodes of the state; they are never both high.

Reset
REQ-027 On reset=1 at a clkIn edge, SHALL clear sync1, sync2, prev, tick, count, wrap and the timer to 0 and set the state to IDLE (running=0, stalled=0).
REQ-028 Reset SHALL override clear, enable and tick, and reset mid-count SHALL discard all progress.
REQ-029 After reset release, slowIn high SHALL NOT produce a tick until a 0->1 transition is seen through the synchronizer.

Configuration
REQ-030 Macro TICK_COUNTER_WATCHDOG_EN SHALL select whether the stall watchdog is compiled in.
REQ-031 With the macro defined, SHALL include a 16-bit timer that is active in RUN, zeroes on tick and increments otherwise.
REQ-032 With the macro defined, SHALL move RUN->STALL at the edge where timer==TIMEOUT-1 and tick=0; if tick and timeout coincide, tick wins and the state stays RUN.
REQ-033 With the macro undefined, SHALL omit the timer and STALL state logic, tie stalled to constant 0, and have RUN be terminal until reset.

Verification
REQ-034 Reset, then drive slowIn with period 8 clkIn cycles (4 high/4 low): each slowIn rise -> tick pulse exactly 3 edges later, width 1, and running=1 after the first tick.
REQ-035 MAX_COUNT=10, enable=1, 25 slowIn periods: count sequence 1..9,0,1..9,0,1..5; wrap pulses twice, each coincident with count=0.
REQ-036 enable=0 for slowIn periods 3-5, then clear=1 asserted in the same cycle as a tick: count holds at 2 through the disabled periods, then reads 0, wrap=0.
REQ-037 TICK_COUNTER_WATCHDOG_EN defined, TIMEOUT=20: stop slowIn after 3 ticks -> stalled=1 exactly 20 cycles after the last tick; restart slowIn -> running=1 on the next tick.
REQ-038 Assert reset at count=7 while slowIn toggles: all outputs 0 on the next edge, state IDLE, and counting restarts from 1 on the first post-reset tick.
